mem_port_arbiter: RTL

- Shares one masked read/write port of the byte-addressed synchronous memory between two requesters: port 0 (core data) and port 1 (host/debug loader).
- The memory registers its read address on the clock edge and returns read data combinationally in the following cycle.
- This block arbitrates requests using round-robin or fixed priority, drives the memory port, and returns one buffered response per accepted request, with its own valid/ready handshake.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg: shared constants and request type for the memory arbiter |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int PORT_CORE = 0;
  localparam int PORT_HOST = 1;

  localparam int MEM_ADDR_W = 21;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

  typedef struct packed {
    logic                  wen;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_MASK_W-1:0] mask;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2: two-input round-robin / fixed-priority arbiter              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // On a tie the port that did not win last time is picked; reset favours port 0.
  always_comb begin
    grant_o      = req_i;
    last_grant_d = last_grant_q;
    if (req_i == 2'b11) begin
      if ((FIXED_PRIO != 0) || last_grant_q) begin
        grant_o = 2'b01;
      end else begin
        grant_o = 2'b10;
      end
    end
    if (|grant_o) begin
      last_grant_d = grant_o[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter: shares one masked memory port between two requesters|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  input  logic [MASK_WIDTH-1:0] req_mask0,
  input  logic [MASK_WIDTH-1:0] req_mask1,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata0,
  output logic [DATA_WIDTH-1:0] resp_rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_mask,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic                  inflight_v_q;
  logic                  inflight_port_q;
  logic                  inflight_read_q;
  logic [1:0]            resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata0_q, resp_rdata0_d;
  logic [DATA_WIDTH-1:0] resp_rdata1_q, resp_rdata1_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic                  gnt_any;
  logic                  gnt_port;

  // A port may not re-issue while its previous request is still in flight, nor
  // while its response slot is full and not being drained this cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign elig[gi] = rst_n & req_valid[gi]
                    & ~(inflight_v_q & (inflight_port_q == 1'(gi)))
                    & (~resp_valid_q[gi] | resp_ready[gi]);
  end

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (elig),
    .grant_o (grant)
  );

  assign gnt_any   = |grant;
  assign gnt_port  = grant[PORT_HOST];
  assign req_ready = grant;

  always_comb begin
    mem_addr  = mem_addr_q;
    mem_wdata = '0;
    mem_mask  = '0;
    mem_wen   = 1'b0;
    if (gnt_any) begin
      if (gnt_port) begin
        mem_addr  = req_addr1;
        mem_wdata = req_wdata1;
        mem_mask  = req_mask1;
        mem_wen   = req_wen[PORT_HOST];
      end else begin
        mem_addr  = req_addr0;
        mem_wdata = req_wdata0;
        mem_mask  = req_mask0;
        mem_wen   = req_wen[PORT_CORE];
      end
    end
  end

  // A landing response takes priority over a drain of the same slot.
  always_comb begin
    resp_valid_d  = resp_valid_q & ~resp_ready;
    resp_rdata0_d = resp_rdata0_q;
    resp_rdata1_d = resp_rdata1_q;
    if (inflight_v_q) begin
      if (inflight_port_q) begin
        resp_valid_d[PORT_HOST] = 1'b1;
        resp_rdata1_d           = inflight_read_q ? mem_rdata : '0;
      end else begin
        resp_valid_d[PORT_CORE] = 1'b1;
        resp_rdata0_d           = inflight_read_q ? mem_rdata : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_v_q    <= 1'b0;
      inflight_port_q <= 1'b0;
      inflight_read_q <= 1'b0;
      resp_valid_q    <= 2'b00;
      resp_rdata0_q   <= '0;
      resp_rdata1_q   <= '0;
      mem_addr_q      <= '0;
    end else begin
      inflight_v_q    <= gnt_any;
      inflight_port_q <= gnt_port;
      inflight_read_q <= ~mem_wen;
      resp_valid_q    <= resp_valid_d;
      resp_rdata0_q   <= resp_rdata0_d;
      resp_rdata1_q   <= resp_rdata1_d;
      mem_addr_q      <= mem_addr;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_rdata0 = resp_rdata0_q;
  assign resp_rdata1 = resp_rdata1_q;

endmodule
`default_nettype wire
